coarse_readout: RTL and testbench

- Reader side of the coarse clock counter in the TDC.
- Captures each finalized stored coarse count after a store window closes and queues it in a small FIFO.
- Emits each queued value as a framed byte stream over a valid/ready interface toward the host link (UART/USB bridge).
- Makes the coarse count observable off-chip without stalling measurement.

---
 rtl/coarse_readout_pkg.sv | 13 +
 rtl/coarse_readout_if.sv | 9 +
 rtl/coarse_readout_fifo.sv | 49 ++++
 rtl/coarse_readout.sv | 103 ++++++++++
 tb/tb_coarse_readout.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/coarse_readout_pkg.sv
// rtl/coarse_readout_pkg.sv - shared types and helpers for the coarse count readout
package tdc_readout_pkg;

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_e;

  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

  // Data bytes needed for a (c_dig+1)-bit coarse word.
  function automatic int nbytes(input int c_dig);
    return (c_dig + 8) / 8;
  endfunction

endpackage

// File: rtl/coarse_readout_if.sv
// rtl/coarse_readout_if.sv - byte stream from the coarse readout toward the host link
interface coarse_readout_if;
  logic [7:0] oData;
  logic       oValid;
  logic       iReady;

  modport master (output oData, output oValid, input iReady);
  modport slave  (input oData, input oValid, output iReady);
endinterface

// File: rtl/coarse_readout_fifo.sv
// rtl/coarse_readout_fifo.sv - small synchronous FIFO holding captured coarse words
module sync_fifo #(
  parameter  int WIDTH = 11,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a full FIFO still takes the word.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/coarse_readout.sv
// rtl/coarse_readout.sv - captures finalized coarse counts and streams them as framed bytes
module coarse_readout
  import tdc_readout_pkg::*;
#(
  parameter  int          C_DIG      = 10,
  parameter  int          FIFO_DEPTH = 4,
  parameter  logic [7:0]  HDR_BYTE   = HDR_BYTE_DEF,
  localparam int          LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                iRst_n,
  input  logic                iStore,
  input  logic [C_DIG:0]      iCoarse,
  coarse_readout_if.master    stream,
  output logic [LW-1:0]       oLevel,
  output logic                oOverflow
);

  localparam int NB = nbytes(C_DIG);
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            store_d_q, ovf_q;
  logic            capture, xfer, pop, more_after_pop;
  logic            full, empty;
  logic [LW-1:0]   level;
  logic [C_DIG:0]  head;
  logic [8*NB-1:0] head_ext;

  assign capture        = store_d_q && !iStore;
  assign xfer           = valid_q && stream.iReady;
  assign pop            = (state_q == DATA) && xfer && (idx_q == '0);
  assign more_after_pop = (level > LW'(1)) || capture;

  sync_fifo #(.WIDTH(C_DIG + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (iRst_n),
    .push_i  (capture),
    .wdata_i (iCoarse),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      store_d_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      store_d_q <= iStore;
      ovf_q     <= ovf_q || (capture && full && !pop);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (!empty) state_d = HDR;
      HDR: if (xfer) begin
        state_d = DATA;
        idx_d   = LAST_IDX;
      end
      DATA: if (xfer) begin
        if (idx_q == '0) state_d = more_after_pop ? HDR : IDLE;
        else             idx_d   = idx_q - IW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // The head word stays in the FIFO until its last byte goes, so it can be re-sliced each cycle.
  always_comb begin
    head_ext           = '0;
    head_ext[C_DIG:0]  = head;
    valid_d            = (state_d != IDLE);
    case (state_d)
      HDR:     data_d = HDR_BYTE;
      DATA:    data_d = 8'(head_ext >> {idx_d, 3'b000});
      default: data_d = '0;
    endcase
  end

  assign stream.oData  = data_q;
  assign stream.oValid = valid_q;
  assign oLevel        = level;
  assign oOverflow     = ovf_q;

endmodule

// File: tb/tb_coarse_readout.sv
// tb/tb_coarse_readout.sv - scoreboard bench for coarse_readout against a byte-queue reference model
module tb_coarse_readout;

  localparam int         C_DIG = 10;
  localparam int         DEPTH = 4;
  localparam int         NB    = (C_DIG + 8) / 8;
  localparam logic [7:0] HDR   = 8'hA5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           store = 1'b0;
  logic [C_DIG:0] coarse = '0;
  logic [2:0]     level;
  logic           ovf;

  coarse_readout_if bus();

  always #5 clk = ~clk;

  coarse_readout #(.C_DIG(C_DIG), .FIFO_DEPTH(DEPTH), .HDR_BYTE(HDR)) dut (
    .clk       (clk),
    .iRst_n    (rst_n),
    .iStore    (store),
    .iCoarse   (coarse),
    .stream    (bus),
    .oLevel    (level),
    .oOverflow (ovf)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending stream bytes, word count, sticky drop flag.
  logic [7:0] exp_q[$];
  int         m_cnt = 0;
  int         m_bidx = 0;
  int         frames_done = 0;
  bit         m_ovf = 0;
  bit         m_prev_store = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_data = '0;

  task automatic push_frame(input logic [C_DIG:0] v);
    logic [8*NB-1:0] ext;
    ext = '0;
    ext[C_DIG:0] = v;
    exp_q.push_back(HDR);
    for (int k = NB - 1; k >= 0; k--) exp_q.push_back(ext[8*k +: 8]);
  endtask

  // Each negedge: check the state left by the last edge, then predict the next edge.
  always @(negedge clk) begin
    logic xfer, pop, cap;
    logic [7:0] e;
    if (!rst_n) begin
      exp_q.delete();
      m_cnt = 0; m_bidx = 0; m_ovf = 0; m_prev_store = 0; prev_stall = 0;
    end else begin
      chk("level", level, m_cnt);
      chk("overflow", ovf, m_ovf);
      if (prev_stall) begin
        chk("hold_valid", bus.oValid, 1);
        chk("hold_data", bus.oData, prev_data);
      end
      xfer = bus.oValid && bus.iReady;
      pop  = 0;
      if (xfer) begin
        if (exp_q.size() == 0) chk("unexpected_byte", bus.oData, 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          chk("stream_byte", bus.oData, e);
        end
        if (m_bidx == NB) begin
          pop = 1; m_bidx = 0; frames_done++;
        end else m_bidx++;
      end
      cap = m_prev_store && !store;
      if (cap) begin
        if (m_cnt < DEPTH || pop) begin
          push_frame(coarse);
          m_cnt++;
        end else m_ovf = 1;
      end
      if (pop) m_cnt--;
      m_prev_store = store;
      prev_stall   = bus.oValid && !bus.iReady;
      prev_data    = bus.oData;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [C_DIG:0] v);
    coarse = v;
    store = 1'b1;
    tick(1);
    store = 1'b0;
    tick(1);
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (exp_q.size() == 0 && !bus.oValid) break;
      tick(1);
    end
    chk("drain_pending", exp_q.size(), 0);
    chk("drain_valid", bus.oValid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    bus.iReady = 1'b0;
    tick(3);
    chk("rst_valid", bus.oValid, 0);
    chk("rst_data", bus.oData, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    tick(2);

    // Single capture, exact cycle timing.
    bus.iReady = 1'b1;
    coarse = 11'h3A7;
    store = 1'b1;
    tick(1);
    store = 1'b0;
    @(posedge clk);
    @(negedge clk); chk("t1_e_valid", bus.oValid, 0); chk("t1_e_level", level, 1);
    @(negedge clk); chk("t1_hdr_valid", bus.oValid, 1); chk("t1_hdr", bus.oData, 8'hA5);
    @(negedge clk); chk("t1_b1", bus.oData, 8'h03);
    @(negedge clk); chk("t1_b0", bus.oData, 8'hA7);
    @(negedge clk); chk("t1_end_valid", bus.oValid, 0); chk("t1_end_level", level, 0);
    tick(2);

    // Backpressure with alternating ready.
    bus.iReady = 1'b0;
    pulse(11'h155);
    for (int i = 0; i < 20; i++) begin
      bus.iReady = i[0];
      tick(1);
    end
    bus.iReady = 1'b1;
    wait_drain(50);

    // Overflow: five captures into a four-deep FIFO.
    bus.iReady = 1'b0;
    for (int v = 1; v <= 5; v++) pulse(11'(v));
    tick(2);
    chk("ovf_level", level, 4);
    chk("ovf_flag", ovf, 1);
    f0 = frames_done;
    bus.iReady = 1'b1;
    wait_drain(100);
    chk("ovf_frames", frames_done - f0, 4);
    chk("ovf_sticky", ovf, 1);

    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Push coinciding with the final-byte pop while full.
    bus.iReady = 1'b0;
    for (int v = 6; v <= 9; v++) pulse(11'(v));
    tick(2);
    chk("full_level", level, 4);
    f0 = frames_done;
    bus.iReady = 1'b1;
    tick(1);
    coarse = 11'd10;
    store = 1'b1;
    tick(1);
    store = 1'b0;
    tick(1);
    chk("full_pushpop_level", level, 4);
    wait_drain(100);
    chk("full_frames", frames_done - f0, 5);
    chk("full_no_ovf", ovf, 0);

    // Store held high while the count advances.
    f0 = frames_done;
    coarse = '0;
    store = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      coarse = coarse + 11'd1;
    end
    chk("hold_no_capture", level, 0);
    store = 1'b0;
    tick(2);
    wait_drain(50);
    chk("hold_frames", frames_done - f0, 1);

    // Reset in the middle of a frame.
    coarse = 11'h2C3;
    store = 1'b1;
    tick(1);
    store = 1'b0;
    tick(3);
    chk("mid_valid_before", bus.oValid, 1);
    rst_n = 1'b0;
    #1;
    chk("async_valid", bus.oValid, 0);
    chk("async_level", level, 0);
    tick(3);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("post_rst_idle", bus.oValid, 0);
    end
    f0 = frames_done;
    pulse(11'h7FF);
    wait_drain(50);
    chk("post_rst_frames", frames_done - f0, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bus.iReady = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) store = ~store;
      coarse = 11'($urandom);
      tick(1);
    end
    store = 1'b0;
    bus.iReady = 1'b1;
    tick(2);
    wait_drain(400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
